// File: rtl/aht_pkg.sv
// Shared constants, FSM state type and helpers
// for the AHT10 frame formatter.
package aht_pkg;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_PCT   = 8'h25;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    localparam logic [3:0] SEG_SEP   = 4'hB;
    localparam logic [3:0] SEG_MINUS = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        CONV_T,
        CONV_H,
        SEND
    } fmt_state_e;

    function automatic int frame_len(input int f, input int crlf);
        return 11 + 2 * f + 2 * crlf;
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] asc_dig(input logic [3:0] d);
        return ASC_ZERO | {4'h0, d};
    endfunction

endpackage

// File: rtl/aht_frame_fmt_if.sv
// Sample input, UART handshake and display
// bundle for the frame formatter.
interface aht_frame_fmt_if #(
    parameter int RAW_W = 20
);
    logic [2*RAW_W-1:0] din;
    logic               din_vld;
    logic               busy;
    logic               tx_byte_vld;
    logic [7:0]         tx_byte;
    logic [23:0]        seg_dout;
    logic               frame_done;
    logic               overrun;

    modport master (
        output din, din_vld, busy,
        input  tx_byte_vld, tx_byte, seg_dout,
        input  frame_done, overrun
    );

    modport slave (
        input  din, din_vld, busy,
        output tx_byte_vld, tx_byte, seg_dout,
        output frame_done, overrun
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble: one load
// cycle, then 16 shift/add-3 cycles.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        done_o,
    output logic [19:0] bcd_o
);
    logic [15:0] bin_q, bin_d;
    logic [18:0] bcd_q, bcd_d;
    logic [15:0] bcd_adj;
    logic [4:0]  cnt_q, cnt_d;

    // Top digit never exceeds 3 before a shift, so only 4 need add-3.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
    end

    // Result is presented as the post-shift value during the final step.
    assign bcd_o  = {bcd_q[18:16], bcd_adj, bin_q[15]};
    assign done_o = (cnt_q == 5'd1);

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (cnt_q != 5'd0) begin
            bin_d = {bin_q[14:0], 1'b0};
            bcd_d = bcd_o[18:0];
            cnt_d = cnt_q - 5'd1;
        end else if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = 5'd16;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aht_frame_fmt.sv
// Scales an AHT10 sample to fixed-point decimal and
// streams it as an ASCII frame plus a 7-seg word.
module aht_frame_fmt
    import aht_pkg::*;
#(
    parameter int RAW_W       = 20,
    parameter int FRAC_DIGITS = 1,
    parameter int ADD_CRLF    = 1
) (
    input logic            clk,
    input logic            rst_n,
    aht_frame_fmt_if.slave bus
);
    localparam int F   = FRAC_DIGITS;
    localparam int L   = frame_len(F, ADD_CRLF);
    localparam int S   = pow10(F + 2);
    localparam int OFF = 5 * pow10(F + 1);
    localparam int PW  = RAW_W + 16;

    fmt_state_e          state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [2*RAW_W-1:0]  sample_q, sample_d;
    logic [19:0]         t_bcd_q, t_bcd_d;
    logic [19:0]         h_bcd_q, h_bcd_d;
    logic                t_neg_q, t_neg_d;
    logic [23:0]         seg_q, seg_d;

    logic [PW-1:0] h_prod, t_prod;
    logic [15:0]   h_val, t_scl, t_mag;
    logic          t_neg;
    logic          conv_start, conv_done;
    logic [15:0]   conv_bin;
    logic [19:0]   conv_bcd;
    logic          vld_c, done_c, ovr_c;
    logic [7:0]    byte_c;
    int            pos;
    logic          unused_bcd;

    // Full-width products; only the shift discards precision.
    assign h_prod = PW'(sample_q[2*RAW_W-1:RAW_W]) * PW'(S);
    assign t_prod = PW'(sample_q[RAW_W-1:0]) * PW'(2 * S);
    assign h_val  = 16'(h_prod >> RAW_W);
    assign t_scl  = 16'(t_prod >> RAW_W);
    assign t_neg  = t_scl < 16'(OFF);
    assign t_mag  = t_neg ? 16'(OFF) - t_scl : t_scl - 16'(OFF);

    assign conv_bin = (state_q == CONV_H) ? h_val : t_mag;

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        t_bcd_d    = t_bcd_q;
        h_bcd_d    = h_bcd_q;
        t_neg_d    = t_neg_q;
        seg_d      = seg_q;
        conv_start = 1'b0;
        vld_c      = 1'b0;
        done_c     = 1'b0;
        ovr_c      = bus.din_vld && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.din_vld) begin
                    sample_d = bus.din;
                    state_d  = CONV_T;
                end
            end
            CONV_T: begin
                conv_start = 1'b1;
                if (conv_done) begin
                    t_bcd_d = conv_bcd;
                    t_neg_d = t_neg;
                    state_d = CONV_H;
                end
            end
            CONV_H: begin
                conv_start = 1'b1;
                if (conv_done) begin
                    h_bcd_d = conv_bcd;
                    seg_d   = {t_neg_q ? SEG_MINUS
                                       : t_bcd_q[4*(F+2) +: 4],
                               t_bcd_q[4*(F+1) +: 4],
                               t_bcd_q[4*F +: 4],
                               SEG_SEP,
                               conv_bcd[4*(F+1) +: 4],
                               conv_bcd[4*F +: 4]};
                    state_d = SEND;
                end
            end
            SEND: begin
                vld_c = !bus.busy;
                if (vld_c) begin
                    if (int'(idx_q) == L - 1) begin
                        idx_d   = '0;
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pos = int'(idx_q);

    always_comb begin
        byte_c = 8'h00;
        if (state_q == SEND) begin
            if (pos == 0)
                byte_c = t_neg_q ? ASC_MINUS : ASC_SPACE;
            else if (pos == 1)
                byte_c = asc_dig(t_bcd_q[4*(F+2) +: 4]);
            else if (pos == 2)
                byte_c = asc_dig(t_bcd_q[4*(F+1) +: 4]);
            else if (pos == 3)
                byte_c = asc_dig(t_bcd_q[4*F +: 4]);
            else if (pos == 4)
                byte_c = ASC_DOT;
            else if (pos == 5)
                byte_c = asc_dig(t_bcd_q[4*(F-1) +: 4]);
            else if (F == 2 && pos == 6)
                byte_c = asc_dig(t_bcd_q[3:0]);
            else if (pos == 5 + F)
                byte_c = ASC_C;
            else if (pos == 6 + F)
                byte_c = ASC_SPACE;
            else if (pos == 7 + F)
                byte_c = asc_dig(h_bcd_q[4*(F+1) +: 4]);
            else if (pos == 8 + F)
                byte_c = asc_dig(h_bcd_q[4*F +: 4]);
            else if (pos == 9 + F)
                byte_c = ASC_DOT;
            else if (pos == 10 + F)
                byte_c = asc_dig(h_bcd_q[4*(F-1) +: 4]);
            else if (F == 2 && pos == 11 + F)
                byte_c = asc_dig(h_bcd_q[3:0]);
            else if (pos == 10 + 2 * F)
                byte_c = ASC_PCT;
            else if (ADD_CRLF == 1 && pos == 11 + 2 * F)
                byte_c = ASC_CR;
            else if (ADD_CRLF == 1 && pos == 12 + 2 * F)
                byte_c = ASC_LF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sample_q <= '0;
            t_bcd_q  <= '0;
            h_bcd_q  <= '0;
            t_neg_q  <= 1'b0;
            seg_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            t_bcd_q  <= t_bcd_d;
            h_bcd_q  <= h_bcd_d;
            t_neg_q  <= t_neg_d;
            seg_q    <= seg_d;
        end
    end

    assign unused_bcd = ^{t_bcd_q, h_bcd_q};

    assign bus.tx_byte_vld = vld_c;
    assign bus.tx_byte     = byte_c;
    assign bus.seg_dout    = seg_q;
    assign bus.frame_done  = done_c;
    assign bus.overrun     = ovr_c;

endmodule
